// File: rtl/ifm_addr_gen_if.sv
// rtl/ifm_addr_gen_if.sv - control, BRAM read and window-stream bundle for ifm_addr_gen
// master = address generator side, slave = surrounding logic.
interface ifm_addr_gen_if;
  logic        start;
  logic        busy;
  logic        done;
  logic [19:0] rd_addr;
  logic [31:0] bram_data;
  logic [31:0] pix_data;
  logic        pix_valid;
  logic        pix_ready;
  logic        win_last;
  logic        map_last;

  modport master (
    input  start, bram_data, pix_ready,
    output busy, done, rd_addr, pix_data, pix_valid, win_last, map_last
  );

  modport slave (
    output start, bram_data, pix_ready,
    input  busy, done, rd_addr, pix_data, pix_valid, win_last, map_last
  );
endinterface

// File: rtl/ifm_addr_gen.sv
// rtl/ifm_addr_gen.sv - sliding-window IFM read address generator with 2-entry skid buffer
// Optional one-pixel zero-padded border: define IFM_ZERO_PAD_EN.
module ifm_addr_gen #(
  parameter int IFM_W    = 16,
  parameter int IFM_H    = 16,
  parameter int CH_WORDS = 4,
  parameter int KERNEL   = 3,
  parameter int STRIDE   = 1
) (
  input  logic          clk,
  input  logic          rst,
  ifm_addr_gen_if.master bus
);
`ifdef IFM_ZERO_PAD_EN
  localparam int PAD = 1;
`else
  localparam int PAD = 0;
`endif
  localparam int OH  = (IFM_H + 2*PAD - KERNEL) / STRIDE + 1;
  localparam int OW  = (IFM_W + 2*PAD - KERNEL) / STRIDE + 1;
  localparam int OYW = (OH > 1) ? $clog2(OH) : 1;
  localparam int OXW = (OW > 1) ? $clog2(OW) : 1;
  localparam int KW  = (KERNEL > 1) ? $clog2(KERNEL) : 1;
  localparam int CWW = (CH_WORDS > 1) ? $clog2(CH_WORDS) : 1;
  localparam logic [OYW-1:0] OY_MAX = OYW'(OH - 1);
  localparam logic [OXW-1:0] OX_MAX = OXW'(OW - 1);
  localparam logic [KW-1:0]  K_MAX  = KW'(KERNEL - 1);
  localparam logic [CWW-1:0] CW_MAX = CWW'(CH_WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t         r_state;
  logic           r_busy, r_done;
  logic [OYW-1:0] r_oy;
  logic [OXW-1:0] r_ox;
  logic [KW-1:0]  r_ky, r_kx;
  logic [CWW-1:0] r_cw;
  logic           r_ret_v, r_ret_wl, r_ret_ml;
  logic [33:0]    r_mem [2];
  logic           r_wp, r_rp;
  logic [1:0]     r_cnt;

  logic           w_cw_end, w_kx_end, w_ky_end, w_ox_end, w_oy_end;
  logic           w_win_last, w_map_last, w_pop, w_issue;
  logic [19:0]    w_addr;
  logic [31:0]    w_push_data;
  logic [33:0]    w_head;

  assign w_cw_end   = (r_cw == CW_MAX);
  assign w_kx_end   = (r_kx == K_MAX);
  assign w_ky_end   = (r_ky == K_MAX);
  assign w_ox_end   = (r_ox == OX_MAX);
  assign w_oy_end   = (r_oy == OY_MAX);
  assign w_win_last = w_cw_end & w_kx_end & w_ky_end;
  assign w_map_last = w_win_last & w_ox_end & w_oy_end;

  assign w_head = r_mem[r_rp];
  assign w_pop  = (r_cnt != 2'd0) && bus.pix_ready;
  // Credit: the read returning now plus words left after this cycle's pop must stay below 2
  assign w_issue = (r_state == RUN) && (({1'b0, r_ret_v} + r_cnt - {1'b0, w_pop}) < 2'd2);

`ifdef IFM_ZERO_PAD_EN
  logic w_pad, r_ret_pad;

  always_comb begin
    int row, col;
    row    = int'(r_oy) * STRIDE + int'(r_ky) - PAD;
    col    = int'(r_ox) * STRIDE + int'(r_kx) - PAD;
    w_pad  = (row < 0) || (row >= IFM_H) || (col < 0) || (col >= IFM_W);
    w_addr = w_pad ? 20'd0 : 20'(((row * IFM_W + col) * CH_WORDS + int'(r_cw)) * 4);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_ret_pad <= 1'b0;
    else     r_ret_pad <= w_issue & w_pad;
  end

  assign w_push_data = r_ret_pad ? 32'd0 : bus.bram_data;
`else
  always_comb begin
    int row, col;
    row    = int'(r_oy) * STRIDE + int'(r_ky);
    col    = int'(r_ox) * STRIDE + int'(r_kx);
    w_addr = 20'(((row * IFM_W + col) * CH_WORDS + int'(r_cw)) * 4);
  end

  assign w_push_data = bus.bram_data;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_oy <= '0; r_ox <= '0; r_ky <= '0; r_kx <= '0; r_cw <= '0;
    end else if (w_issue) begin
      r_cw <= w_cw_end ? '0 : r_cw + 1'b1;
      if (w_cw_end) begin
        r_kx <= w_kx_end ? '0 : r_kx + 1'b1;
        if (w_kx_end) begin
          r_ky <= w_ky_end ? '0 : r_ky + 1'b1;
          if (w_ky_end) begin
            r_ox <= w_ox_end ? '0 : r_ox + 1'b1;
            if (w_ox_end) r_oy <= w_oy_end ? '0 : r_oy + 1'b1;
          end
        end
      end
    end
  end

  // Tags ride alongside the BRAM read so they land in the skid buffer with their word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ret_v <= 1'b0; r_ret_wl <= 1'b0; r_ret_ml <= 1'b0;
      r_wp <= 1'b0; r_rp <= 1'b0; r_cnt <= 2'd0;
    end else begin
      r_ret_v  <= w_issue;
      r_ret_wl <= w_win_last;
      r_ret_ml <= w_map_last;
      if (r_ret_v) r_wp <= ~r_wp;
      if (w_pop)   r_rp <= ~r_rp;
      r_cnt <= r_cnt + {1'b0, r_ret_v} - {1'b0, w_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (r_ret_v) r_mem[r_wp] <= {r_ret_ml, r_ret_wl, w_push_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE; r_busy <= 1'b0; r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE:  if (bus.start) begin
                 r_state <= RUN;
                 r_busy  <= 1'b1;
               end
        RUN:   if (w_issue && w_map_last) r_state <= DRAIN;
        DRAIN: if (w_pop && w_head[33]) begin
                 r_state <= IDLE;
                 r_busy  <= 1'b0;
                 r_done  <= 1'b1;
               end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.rd_addr   = w_addr;
  assign bus.pix_valid = (r_cnt != 2'd0);
  assign bus.pix_data  = (r_cnt != 2'd0) ? w_head[31:0] : 32'd0;
  assign bus.win_last  = (r_cnt != 2'd0) && w_head[32];
  assign bus.map_last  = (r_cnt != 2'd0) && w_head[33];
endmodule

// File: tb/tb_ifm_addr_gen.sv
// tb/tb_ifm_addr_gen.sv - self-checking bench for ifm_addr_gen
// Table of traversal runs plus a mid-run reset sequence; scoreboard queue of expected words.
module tb_ifm_addr_gen;
`ifdef IFM_ZERO_PAD_EN
  localparam int W = 4, H = 4, CW = 1, PAD = 1;
`else
  localparam int W = 16, H = 16, CW = 4, PAD = 0;
`endif
  localparam int K = 3, S = 1;
  localparam int OH = (H + 2*PAD - K) / S + 1;
  localparam int OW = (W + 2*PAD - K) / S + 1;
  localparam int WIN = K * K * CW;
  localparam int TOTAL = OH * OW * WIN;
  localparam int RST_AT = (TOTAL > 1000) ? 1000 : TOTAL / 2;

  typedef struct { logic [31:0] data; logic wl; logic ml; } exp_t;
  typedef struct { int mode; bit pulse; int exp_words; int exp_lat; } rec_t;

  logic clk = 1'b0;
  logic rst;
  ifm_addr_gen_if bus();

  ifm_addr_gen #(.IFM_W(W), .IFM_H(H), .CH_WORDS(CW), .KERNEL(K), .STRIDE(S)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  exp_t        exp_q[$];
  logic [19:0] addr_q[$];
  exp_t        e_pop, prev_word;
  logic [31:0] first_win[9];
  int n_checks = 0, n_fail = 0, cyc = 0, rx_count = 0, done_count = 0, ml_cyc = -10, mode = 0;
  bit mon_en = 1'b0, prev_stall = 1'b0;
  rec_t tbl[5];

  function automatic logic [31:0] bram_word(input int idx);
    return (32'(idx) * 32'h0100_0193) ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference traversal: oy, ox, ky, kx, cw outermost to innermost
  task automatic build_expected();
    exp_t e;
    int row, col, idx;
    bit pad;
    exp_q.delete();
    addr_q.delete();
    for (int oy = 0; oy < OH; oy++)
      for (int ox = 0; ox < OW; ox++)
        for (int ky = 0; ky < K; ky++)
          for (int kx = 0; kx < K; kx++)
            for (int cw = 0; cw < CW; cw++) begin
              row = oy*S + ky - PAD;
              col = ox*S + kx - PAD;
              pad = (row < 0) || (row >= H) || (col < 0) || (col >= W);
              idx = (row*W + col)*CW + cw;
              e.data = pad ? 32'd0 : bram_word(idx);
              e.wl = (ky == K-1) && (kx == K-1) && (cw == CW-1);
              e.ml = e.wl && (oy == OH-1) && (ox == OW-1);
              exp_q.push_back(e);
              addr_q.push_back(pad ? 20'd0 : 20'(idx*4));
            end
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    bus.bram_data <= bram_word(int'(bus.rd_addr >> 2));
  end

  initial begin
    bus.pix_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (mode)
        0:       bus.pix_ready = 1'b1;
        1:       bus.pix_ready = ~bus.pix_ready;
        default: bus.pix_ready = ($urandom_range(99) >= 30);
      endcase
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (prev_stall) begin
        chk("stall_valid", 32'(bus.pix_valid), 32'd1);
        chk("stall_data", bus.pix_data, prev_word.data);
        chk("stall_flags", {30'd0, bus.win_last, bus.map_last}, {30'd0, prev_word.wl, prev_word.ml});
      end
      prev_stall = bus.pix_valid && !bus.pix_ready;
      prev_word.data = bus.pix_data;
      prev_word.wl = bus.win_last;
      prev_word.ml = bus.map_last;
      if (bus.pix_valid && bus.pix_ready) begin
        rx_count++;
        if (rx_count <= 9) first_win[rx_count-1] = bus.pix_data;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL extra_word: got word %0d, expected none", rx_count);
        end else begin
          e_pop = exp_q.pop_front();
          chk("pix_data", bus.pix_data, e_pop.data);
          chk("word_flags", {30'd0, bus.win_last, bus.map_last}, {30'd0, e_pop.wl, e_pop.ml});
        end
        if (rx_count == WIN) chk("first_win_last", 32'(bus.win_last), 32'd1);
        if (rx_count == TOTAL) chk("final_flags", {30'd0, bus.win_last, bus.map_last}, 32'd3);
        if (bus.map_last) ml_cyc = cyc;
      end
      if (bus.done) begin
        done_count++;
        chk("done_gap", 32'(cyc), 32'(ml_cyc + 1));
      end
    end
  end

  task automatic run_map(input rec_t r);
    int lat, t;
    build_expected();
    rx_count = 0; done_count = 0; ml_cyc = -10; mode = r.mode;
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (i == 1) chk("busy_after_start", 32'(bus.busy), 32'd1);
`ifndef IFM_ZERO_PAD_EN
      if (r.mode == 0) chk("rd_addr", 32'(bus.rd_addr), 32'(addr_q[i-1]));
`endif
      if (lat < 0 && bus.pix_valid) lat = i - 1;
    end
    chk("latency", 32'(lat), 32'(r.exp_lat));
    t = 0;
    while (done_count == 0 && t < 40000) begin
      @(posedge clk); #1;
      bus.start = r.pulse && (t == 100);
      t++;
    end
    bus.start = 1'b0;
    if (done_count == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: no done after %0d cycles", t);
    end
    repeat (5) @(negedge clk);
    chk("word_count", 32'(rx_count), 32'(r.exp_words));
    chk("done_count", 32'(done_count), 32'd1);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    chk("busy_idle", 32'(bus.busy), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_done"}, 32'(bus.done), 32'd0);
    chk({tag, "_valid"}, 32'(bus.pix_valid), 32'd0);
    chk({tag, "_win_last"}, 32'(bus.win_last), 32'd0);
    chk({tag, "_map_last"}, 32'(bus.map_last), 32'd0);
    chk({tag, "_rd_addr"}, 32'(bus.rd_addr), 32'd0);
    chk({tag, "_pix_data"}, bus.pix_data, 32'd0);
  endtask

  task automatic reset_mid();
    int t, seen;
    build_expected();
    rx_count = 0; done_count = 0; mode = 0;
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    t = 0;
    while (rx_count < RST_AT && t < 5000) begin
      @(posedge clk); #2;
      t++;
    end
    chk("reset_point", 32'(rx_count), 32'(RST_AT));
    rst = 1'b1;
    mon_en = 1'b0;
    prev_stall = 1'b0;
    @(negedge clk);
    check_all_zero("mid_rst");
    @(posedge clk); #1 rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.done || bus.pix_valid || bus.busy) seen++;
    end
    chk("quiet_after_rst", 32'(seen), 32'd0);
    exp_q.delete();
    mon_en = 1'b1;
    run_map(tbl[0]);
  endtask

  initial begin
    tbl[0] = '{0, 1'b0, TOTAL, 2};
    tbl[1] = '{1, 1'b0, TOTAL, 2};
    tbl[2] = '{2, 1'b0, TOTAL, 2};
    tbl[3] = '{0, 1'b1, TOTAL, 2};
    tbl[4] = '{2, 1'b1, TOTAL, 2};
    bus.start = 1'b0;
    rst = 1'b0;
    #1 rst = 1'b1;
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1 rst = 1'b0;
    mon_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      run_map(tbl[i]);
`ifdef IFM_ZERO_PAD_EN
      if (i == 0) begin
        for (int j = 0; j < 4; j++) chk("pad_zero", first_win[j], 32'd0);
        chk("pad_zero6", first_win[6], 32'd0);
        chk("pad_word4", first_win[4], bram_word(0));
      end
`endif
    end
    reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
